// File: rtl/sa_sched_if.sv
// Host-side and array-side signal bundle for the systolic array scheduler.
// The slave modport is the scheduler's view; the master modport is the view of the host and array around it.
interface sa_sched_if #(
    parameter int DIMENSION = 4,
    parameter int BIT_W     = 32,
    parameter int LEN_W     = 16
);
    logic                             start;
    logic [LEN_W-1:0]                 len;
    logic                             w_load;
    logic [DIMENSION*DIMENSION*BIT_W-1:0] w_data;
    logic                             in_valid;
    logic [DIMENSION*BIT_W-1:0]       in_data;
    logic                             in_ready;
    logic [DIMENSION*BIT_W-1:0]       sa_left;
    logic [DIMENSION*BIT_W-1:0]       sa_top;
    logic [DIMENSION*DIMENSION*BIT_W-1:0] sa_weights;
    logic [DIMENSION*BIT_W-1:0]       sa_right;
    logic                             out_valid;
    logic [DIMENSION*BIT_W-1:0]       out_data;
    logic                             busy;
    logic                             done;

    modport slave (
        input  start, len, w_load, w_data, in_valid, in_data, sa_right,
        output in_ready, sa_left, sa_top, sa_weights, out_valid, out_data, busy, done
    );

    modport master (
        output start, len, w_load, w_data, in_valid, in_data, sa_right,
        input  in_ready, sa_left, sa_top, sa_weights, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/sa_sched.sv
// Systolic array job scheduler: skews activation vectors into the array, deskews the results,
// and tracks each job through IDLE/STREAM/DRAIN with a token pipeline that marks valid results.
module sa_sched #(
    parameter int DIMENSION = 4,
    parameter int BIT_W     = 32,
    parameter int SA_LAT    = 4,
    parameter int LEN_W     = 16
) (
    input  logic     clk,
    input  logic     rst,
    sa_sched_if.slave sif
);
    localparam int LAT_TOT = SA_LAT + DIMENSION - 1;
    localparam int DCNT_W  = $clog2(LAT_TOT + 1);
    localparam int W_W     = DIMENSION * DIMENSION * BIT_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic                done_q, done_d;
    logic [W_W-1:0]      w_q, w_d;
    logic [LAT_TOT:0]    tok_q, tok_d;
    logic                accept_s;
    logic [BIT_W-1:0]    left_s [DIMENSION];
    logic [BIT_W-1:0]    res_s  [DIMENSION];

    assign accept_s = sif.in_valid && (state_q == S_STREAM);

    // Job sequencing, weight capture and end-of-job pulse.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        done_d  = 1'b0;
        w_d     = w_q;
        tok_d   = {tok_q[LAT_TOT-1:0], accept_s};
        case (state_q)
            S_IDLE: begin
                if (sif.w_load) begin
                    w_d = sif.w_data;
                end else begin
                    w_d = w_q;
                end
                if (sif.start && (sif.len == '0)) begin
                    done_d = 1'b1;
                end else if (sif.start) begin
                    state_d = S_STREAM;
                    len_d   = sif.len;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (accept_s && (cnt_q == len_q - LEN_W'(1))) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                    dcnt_d  = '0;
                end else if (accept_s) begin
                    cnt_d = cnt_q + LEN_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_DRAIN: begin
                // done is registered, so raise it one cycle early to land on the last result
                if (dcnt_q == DCNT_W'(LAT_TOT - 1)) begin
                    done_d = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
                if (dcnt_q == DCNT_W'(LAT_TOT)) begin
                    state_d = S_IDLE;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and weight registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            done_q  <= 1'b0;
            w_q     <= '0;
            tok_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            done_q  <= done_d;
            w_q     <= w_d;
            tok_q   <= tok_d;
        end
    end

    for (genvar g = 0; g < DIMENSION; g++) begin : g_lane
        localparam int SKD = g + 1;
        localparam int DSD = DIMENSION - 1 - g;

        logic [BIT_W-1:0] skew_q [SKD];
        logic [BIT_W-1:0] skew_d [SKD];

        // Skew shift register; idle cycles push zeros so the array sees clean bubbles.
        always_comb begin
            skew_d[0] = accept_s ? sif.in_data[g*BIT_W +: BIT_W] : '0;
            for (int s = 1; s < SKD; s++) begin
                skew_d[s] = skew_q[s-1];
            end
        end

        // Skew stage registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < SKD; s++) begin
                    skew_q[s] <= '0;
                end
            end else begin
                skew_q <= skew_d;
            end
        end

        assign left_s[g] = skew_q[SKD-1];

        if (DSD > 0) begin : g_dsk
            logic [BIT_W-1:0] dsk_q [DSD];
            logic [BIT_W-1:0] dsk_d [DSD];

            // Deskew shift register aligning this lane with the last lane.
            always_comb begin
                dsk_d[0] = sif.sa_right[g*BIT_W +: BIT_W];
                for (int s = 1; s < DSD; s++) begin
                    dsk_d[s] = dsk_q[s-1];
                end
            end

            // Deskew stage registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < DSD; s++) begin
                        dsk_q[s] <= '0;
                    end
                end else begin
                    dsk_q <= dsk_d;
                end
            end

            assign res_s[g] = dsk_q[DSD-1];
        end else begin : g_nodsk
            assign res_s[g] = sif.sa_right[g*BIT_W +: BIT_W];
        end
    end

    // Pack per-lane feeds and results onto the bus.
    always_comb begin
        sif.sa_left  = '0;
        sif.out_data = '0;
        for (int i = 0; i < DIMENSION; i++) begin
            sif.sa_left[i*BIT_W +: BIT_W]  = left_s[i];
            sif.out_data[i*BIT_W +: BIT_W] = res_s[i];
        end
    end

    assign sif.sa_top     = '0;
    assign sif.sa_weights = w_q;
    assign sif.in_ready   = (state_q == S_STREAM);
    assign sif.busy       = (state_q != S_IDLE);
    assign sif.done       = done_q;
    assign sif.out_valid  = tok_q[LAT_TOT];
endmodule
